// File: rtl/pc_sequencer_pkg.sv
// Shared opcode definitions for the program-counter sequencer
// and any decoder that drives it.
package pc_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_INC    = 3'd0,
    OP_HOLD   = 3'd1,
    OP_LOAD   = 3'd2,
    OP_BRANCH = 3'd3,
    OP_CALL   = 3'd4,
    OP_RET    = 3'd5
  } pc_op_t;

endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// LIFO return-address stack; entry storage is intentionally
// left unreset, only the occupancy level is cleared.
module ret_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    rd_idx;

  assign wr_idx = level[AW-1:0];
  assign rd_idx = wr_idx - AW'(1);
  assign dout   = mem[rd_idx];

  always_ff @(posedge clk) begin
    if (push) mem[wr_idx] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= '0;
    end else if (push) begin
      level <= level + 1'b1;
    end else if (pop) begin
      level <= level - 1'b1;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter with increment, load, relative branch and
// call/return through a small hardware return stack.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int              WIDTH        = 8,
  parameter int              STEP         = 1,
  parameter int              DEPTH        = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                   CLOCK,
  input  logic                   RESET,
  input  logic                   ENABLE,
  input  logic [OP_W-1:0]        OP,
  input  logic [WIDTH-1:0]       DATA,
  input  logic [WIDTH-1:0]       OFFSET,
  input  logic                   CLR_ERR,
  output logic [WIDTH-1:0]       COUNT,
  output logic                   WRAP,
  output logic [$clog2(DEPTH):0] STACK_LEVEL,
  output logic                   STACK_FULL,
  output logic                   STACK_EMPTY,
  output logic                   ERROR
);

  localparam int LW = $clog2(DEPTH) + 1;

  pc_op_t           op_e;
  logic             is_inc, is_load, is_branch;
  logic             is_call, is_ret;
  logic             push, pop, err_set;
  logic [WIDTH:0]   inc_sum, br_sum;
  logic [WIDTH-1:0] top;

  assign op_e      = pc_op_t'(OP);
  assign is_inc    = op_e == OP_INC;
  assign is_load   = op_e == OP_LOAD;
  assign is_branch = op_e == OP_BRANCH;
  assign is_call   = op_e == OP_CALL;
  assign is_ret    = op_e == OP_RET;

  // One extra bit catches carry out and signed over/underflow.
  assign inc_sum = {1'b0, COUNT} + (WIDTH+1)'(STEP);
  assign br_sum  = {1'b0, COUNT} + {OFFSET[WIDTH-1], OFFSET};

  assign STACK_FULL  = STACK_LEVEL == LW'(DEPTH);
  assign STACK_EMPTY = STACK_LEVEL == '0;

  assign push    = ENABLE & is_call & ~STACK_FULL;
  assign pop     = ENABLE & is_ret & ~STACK_EMPTY;
  assign err_set = ENABLE &
                   ((is_call & STACK_FULL) |
                    (is_ret & STACK_EMPTY));

  ret_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk   (CLOCK),
    .rst_n (RESET),
    .push  (push),
    .pop   (pop),
    .din   (inc_sum[WIDTH-1:0]),
    .dout  (top),
    .level (STACK_LEVEL)
  );

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      COUNT <= RESET_VECTOR;
      WRAP  <= 1'b0;
      ERROR <= 1'b0;
    end else begin
      WRAP <= 1'b0;
      if (ENABLE) begin
        unique case (1'b1)
          is_inc: begin
            COUNT <= inc_sum[WIDTH-1:0];
            WRAP  <= inc_sum[WIDTH];
          end
          is_branch: begin
            COUNT <= br_sum[WIDTH-1:0];
            WRAP  <= br_sum[WIDTH];
          end
          is_load: COUNT <= DATA;
          push:    COUNT <= DATA;
          pop:     COUNT <= top;
          default: ;
        endcase
      end
      if (err_set) ERROR <= 1'b1;
      else if (CLR_ERR) ERROR <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed and random checks of pc_sequencer against a
// queue-based reference model.
module tb_pc_sequencer;

  logic       CLOCK = 1'b0;
  logic       RESET;
  logic       ENABLE;
  logic [2:0] OP;
  logic [7:0] DATA;
  logic [7:0] OFFSET;
  logic       CLR_ERR;
  logic [7:0] COUNT;
  logic       WRAP;
  logic [2:0] STACK_LEVEL;
  logic       STACK_FULL;
  logic       STACK_EMPTY;
  logic       ERROR;

  int checks   = 0;
  int failures = 0;

  int m_cnt;
  int m_stk[$];
  bit m_err;
  bit m_wrap;

  pc_sequencer #(
    .WIDTH        (8),
    .STEP         (1),
    .DEPTH        (4),
    .RESET_VECTOR (8'h00)
  ) dut (
    .CLOCK       (CLOCK),
    .RESET       (RESET),
    .ENABLE      (ENABLE),
    .OP          (OP),
    .DATA        (DATA),
    .OFFSET      (OFFSET),
    .CLR_ERR     (CLR_ERR),
    .COUNT       (COUNT),
    .WRAP        (WRAP),
    .STACK_LEVEL (STACK_LEVEL),
    .STACK_FULL  (STACK_FULL),
    .STACK_EMPTY (STACK_EMPTY),
    .ERROR       (ERROR)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_all(string tag);
    chk({tag, " count"}, 32'(COUNT), 32'(m_cnt));
    chk({tag, " wrap"}, 32'(WRAP), 32'(m_wrap));
    chk({tag, " level"}, 32'(STACK_LEVEL),
        32'(m_stk.size()));
    chk({tag, " full"}, 32'(STACK_FULL),
        32'(m_stk.size() == 4));
    chk({tag, " empty"}, 32'(STACK_EMPTY),
        32'(m_stk.size() == 0));
    chk({tag, " error"}, 32'(ERROR), 32'(m_err));
  endtask

  // Reference behaviour from the operation definitions.
  task automatic model(bit en, int op, int d, int o,
                       bit clr);
    int s;
    bit set;
    set = en && ((op == 4 && m_stk.size() == 4) ||
                 (op == 5 && m_stk.size() == 0));
    m_wrap = 0;
    if (en) begin
      case (op)
        0: begin
          s = m_cnt + 1;
          m_wrap = s > 255;
          m_cnt = s % 256;
        end
        2: m_cnt = d;
        3: begin
          s = m_cnt + (o >= 128 ? o - 256 : o);
          m_wrap = (s < 0) || (s > 255);
          m_cnt = (s + 256) % 256;
        end
        4: if (m_stk.size() < 4) begin
          m_stk.push_back((m_cnt + 1) % 256);
          m_cnt = d;
        end
        5: if (m_stk.size() > 0) m_cnt = m_stk.pop_back();
        default: ;
      endcase
    end
    if (set) m_err = 1;
    else if (clr) m_err = 0;
  endtask

  task automatic cyc(string tag, bit en, int op, int d,
                     int o, bit clr);
    logic [31:0] v_op, v_d, v_o;
    v_op = 32'(op);
    v_d = 32'(d);
    v_o = 32'(o);
    ENABLE  = en;
    OP      = v_op[2:0];
    DATA    = v_d[7:0];
    OFFSET  = v_o[7:0];
    CLR_ERR = clr;
    @(posedge CLOCK);
    #1;
    model(en, op, d, o, clr);
    chk_all(tag);
  endtask

  task automatic async_reset(string tag);
    @(posedge CLOCK);
    #3;
    RESET = 1'b0;
    #1;
    m_cnt = 0;
    m_wrap = 0;
    m_err = 0;
    m_stk.delete();
    chk_all(tag);
    #1;
    RESET = 1'b1;
  endtask

  initial begin
    RESET = 1'b0;
    ENABLE = 1'b0;
    OP = 3'd1;
    DATA = '0;
    OFFSET = '0;
    CLR_ERR = 1'b0;
    m_cnt = 0;
    m_err = 0;
    m_wrap = 0;
    #12;
    chk_all("reset");
    #4;
    RESET = 1'b1;

    cyc("inc1", 1, 0, 0, 0, 0);
    cyc("inc2", 1, 0, 0, 0, 0);
    cyc("inc3", 1, 0, 0, 0, 0);
    chk("seq three", 32'(COUNT), 32'h3);
    cyc("load", 1, 2, 'hFE, 0, 0);
    cyc("inc ff", 1, 0, 0, 0, 0);
    chk("no early wrap", 32'(WRAP), 32'h0);
    cyc("inc wrap", 1, 0, 0, 0, 0);
    chk("wrap pulse", 32'(WRAP), 32'h1);
    cyc("hold", 1, 1, 0, 0, 0);
    chk("wrap one cycle", 32'(WRAP), 32'h0);

    cyc("load10", 1, 2, 'h10, 0, 0);
    cyc("br back", 1, 3, 0, 'hF8, 0);
    chk("br 08", 32'(COUNT), 32'h08);
    cyc("load04", 1, 2, 'h04, 0, 0);
    cyc("br under", 1, 3, 0, 'hF8, 0);
    chk("br fc wrap", 32'({WRAP, COUNT}), 32'h1FC);
    cyc("load f0", 1, 2, 'hF0, 0, 0);
    cyc("br over", 1, 3, 0, 'h7F, 0);

    cyc("load20", 1, 2, 'h20, 0, 0);
    cyc("call", 1, 4, 'h80, 0, 0);
    cyc("inc in sub", 1, 0, 0, 0, 0);
    cyc("ret", 1, 5, 0, 0, 0);
    chk("ret 21", 32'({STACK_LEVEL, COUNT}), 32'h021);

    for (int i = 0; i < 4; i++)
      cyc("call n", 1, 4, 'h40 + 16 * i, 0, 0);
    cyc("call full", 1, 4, 'hAA, 0, 0);
    chk("full err", 32'({ERROR, STACK_FULL, COUNT}),
        32'h370);
    for (int i = 0; i < 4; i++)
      cyc("ret n", 1, 5, 0, 0, 0);
    cyc("ret empty", 1, 5, 0, 0, 0);
    cyc("clr held", 0, 1, 0, 0, 1);
    chk("clr err", 32'(ERROR), 32'h0);
    cyc("ret set", 1, 5, 0, 0, 1);
    chk("err over clr", 32'(ERROR), 32'h1);
    cyc("clr", 1, 1, 0, 0, 1);

    cyc("call a", 1, 4, 'h30, 0, 0);
    for (int i = 0; i < 3; i++)
      cyc("stall", 0, 4, 'h99, 0, 0);
    cyc("call b", 1, 4, 'h50, 0, 0);
    async_reset("async rst");
    cyc("post rst", 1, 0, 0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      int op;
      op = (i % 5 == 0) ? 4 + int'($urandom_range(0, 1))
                        : int'($urandom_range(0, 7));
      cyc("rand", $urandom_range(0, 3) != 0, op,
          int'($urandom_range(0, 255)),
          int'($urandom_range(0, 255)),
          $urandom_range(0, 7) == 0);
      if (i == 200) async_reset("rand rst");
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
